// File: rtl/conv_20_sdiv_seq_pkg.sv
// rtl/conv_20_sdiv_seq_pkg.sv - shared widths, FSM states and saturation limits for the conv_20 divider
// Contents:
//   DEF_DIVIDEND_W / DEF_DIVISOR_W / DEF_QUOT_W  default operand and result widths
//   CNT_W                                        iteration counter width
//   state_t                                      divider FSM states
//   Q_MAX / Q_MIN                                signed quotient clamp limits
package conv_20_div_pkg;

  localparam int DEF_DIVIDEND_W = 24;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int DEF_QUOT_W     = 16;
  localparam int CNT_W          = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DEF_QUOT_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DEF_QUOT_W-1:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/conv_20_sdiv_seq_if.sv
// rtl/conv_20_sdiv_seq_if.sv - operand/result handshake bundle of the conv_20 divider
// Signals:
//   in_valid / in_ready     operand pair handshake
//   dividend / divisor      signed operands
//   out_valid / out_ready   result handshake
//   quotient / remainder    signed results
//   ovf / div_by_zero       result status flags
// Modports: master = producer of operands / consumer of results, slave = the divider.
interface conv_20_sdiv_seq_if
  import conv_20_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int QUOT_W     = DEF_QUOT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  ovf;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, div_by_zero
  );

endinterface

// File: rtl/conv_20_sdiv_seq_step.sv
// rtl/conv_20_sdiv_seq_step.sv - one combinational restoring-division iteration
// Ports:
//   rem_in   in   partial remainder (DIVISOR_W+1 bits)
//   bit_in   in   next dividend bit shifted into the remainder
//   dvs_mag  in   divisor magnitude
//   rem_out  out  next partial remainder
//   q_bit    out  quotient bit produced by this iteration
module conv_20_sdiv_step
  import conv_20_div_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] dvs_mag,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  // The trial subtraction is non-negative exactly when the shifted remainder
  // is >= the divisor, so the compare stands in for the difference's sign bit.
  always_comb begin
    q_bit   = ({rem_in, bit_in} >= (DIVISOR_W+2)'(dvs_mag));
    rem_out = q_bit ? (DIVISOR_W+1)'({rem_in, bit_in} - (DIVISOR_W+2)'(dvs_mag))
                    : (DIVISOR_W+1)'({rem_in, bit_in});
  end

endmodule

// File: rtl/conv_20_sdiv_seq.sv
// rtl/conv_20_sdiv_seq.sv - multi-cycle signed 24/8 divider, 16-bit saturated quotient
// Ports:
//   ap_clk    in  clock, rising edge
//   ap_rst_n  in  asynchronous active-low reset
//   bus       slave modport of conv_20_sdiv_seq_if (operand and result handshakes)
// One quotient bit is resolved per clock on the operand magnitudes; signs are
// reapplied and the quotient clamped when the last bit is produced.
module conv_20_sdiv_seq
  import conv_20_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int QUOT_W     = DEF_QUOT_W
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  conv_20_sdiv_seq_if.slave bus
);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [DIVIDEND_W-1:0]  dvd_sr;     // dividend magnitude, refilled with quotient bits
  logic [DIVISOR_W-1:0]   dvs_mag;
  logic [DIVISOR_W:0]     prem;
  logic                   sign_q;
  logic                   sign_r;
  logic                   zero_div;

  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [QUOT_W-1:0]      quot_q;
  logic [DIVISOR_W-1:0]   rem_q;
  logic                   ovf_q;
  logic                   dbz_q;

  logic [DIVISOR_W:0]     prem_nx;
  logic                   q_bit;
  logic [DIVIDEND_W-1:0]  dvd_abs;
  logic [DIVISOR_W-1:0]   dvs_abs;
  logic [DIVIDEND_W-1:0]  qm_fin;
  logic [DIVISOR_W-1:0]   rm_fin;
  logic [QUOT_W-1:0]      sat_q;
  logic                   sat_ovf;
  logic [DIVISOR_W-1:0]   rem_signed;

  conv_20_sdiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (prem),
    .bit_in  (dvd_sr[DIVIDEND_W-1]),
    .dvs_mag (dvs_mag),
    .rem_out (prem_nx),
    .q_bit   (q_bit)
  );

  // Two's-complement magnitude; the most negative value maps onto its
  // unsigned magnitude (e.g. -2^23 -> 0x800000, -128 -> 128).
  always_comb begin
    dvd_abs = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    dvs_abs = bus.divisor[DIVISOR_W-1]   ? (~bus.divisor + 1'b1)  : bus.divisor;
  end

  // Final unsigned results as they stand after the current iteration.
  always_comb begin
    qm_fin = {dvd_sr[DIVIDEND_W-2:0], q_bit};
    rm_fin = prem_nx[DIVISOR_W-1:0];
  end

  // A negative quotient may reach |Q_MIN|, a positive one only Q_MAX.
  always_comb begin
    sat_q   = QUOT_W'(qm_fin);
    sat_ovf = 1'b0;
    if (sign_q) begin
      if (qm_fin > DIVIDEND_W'(Q_MIN)) begin
        sat_q   = QUOT_W'(Q_MIN);
        sat_ovf = 1'b1;
      end else begin
        sat_q = QUOT_W'(~qm_fin + 1'b1);
      end
    end else if (qm_fin > DIVIDEND_W'(Q_MAX)) begin
      sat_q   = QUOT_W'(Q_MAX);
      sat_ovf = 1'b1;
    end
  end

  // |remainder| < |divisor| <= 2^(DIVISOR_W-1), so negation cannot overflow.
  always_comb begin
    rem_signed = sign_r ? (~rm_fin + 1'b1) : rm_fin;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_sr      <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            dvd_sr     <= dvd_abs;
            dvs_mag    <= dvs_abs;
            sign_q     <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
            sign_r     <= bus.dividend[DIVIDEND_W-1];
            prem       <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= CALC;
            // A zero divisor takes a single pass through CALC so its result
            // lands one edge after acceptance.
            zero_div   <= (bus.divisor == '0);
            cnt        <= (bus.divisor == '0) ? '0 : CNT_W'(DIVIDEND_W-1);
          end
        end

        CALC: begin
          prem   <= prem_nx;
          dvd_sr <= qm_fin;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            if (zero_div) begin
              quot_q <= sign_r ? QUOT_W'(Q_MIN) : QUOT_W'(Q_MAX);
              rem_q  <= '0;
              ovf_q  <= 1'b0;
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= sat_q;
              rem_q  <= rem_signed;
              ovf_q  <= sat_ovf;
              dbz_q  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.ovf         = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_conv_20_sdiv_seq.sv
// tb/tb_conv_20_sdiv_seq.sv - directed self-checking bench for conv_20_sdiv_seq
module tb_conv_20_sdiv_seq;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  conv_20_sdiv_seq_if bus ();

  conv_20_sdiv_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),    32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
    chk({tag, "_q"},         32'(bus.quotient),    32'd0);
    chk({tag, "_r"},         32'(bus.remainder),   32'd0);
    chk({tag, "_ovf"},       32'(bus.ovf),         32'd0);
    chk({tag, "_dbz"},       32'(bus.div_by_zero), 32'd0);
  endtask

  // Issues one operation and checks latency, results, hold behaviour and release.
  task automatic run_op(input string tag, input int a, input int b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input logic eovf, input logic edbz, input int elat,
                        input int hold, input bit disturb);
    int lat;
    @(negedge ap_clk);
    chk({tag, "_rdy_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = 24'(a);
    bus.divisor  = 8'(b);
    @(posedge ap_clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, "_rdy_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (disturb) begin
        bus.in_valid = 1'b1;
        bus.dividend = 24'($urandom());
        bus.divisor  = 8'($urandom());
      end
      @(posedge ap_clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat),             32'(elat));
    chk({tag, "_q"},   32'(bus.quotient),    32'(eq));
    chk({tag, "_r"},   32'(bus.remainder),   32'(er));
    chk({tag, "_ovf"}, 32'(bus.ovf),         32'(eovf));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge ap_clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_rdy"},   32'(bus.in_ready),  32'd0);
      chk({tag, "_hold_q"},     32'(bus.quotient),  32'(eq));
      chk({tag, "_hold_r"},     32'(bus.remainder), 32'(er));
    end
    bus.out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rel_rdy"},   32'(bus.in_ready),  32'd1);
    chk({tag, "_rel_q"},     32'(bus.quotient),  32'(eq));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge ap_clk);
    #1;
    chk_reset_vals("reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_op("p1000_7",   1000,      7, 16'd142,  8'd6,   1'b0, 1'b0, 24, 10, 1'b0);
    run_op("m1000_7",  -1000,      7, 16'hFF72, 8'hFA,  1'b0, 1'b0, 24, 0,  1'b1);
    run_op("p1000_m7",  1000,     -7, 16'hFF72, 8'd6,   1'b0, 1'b0, 24, 0,  1'b0);
    run_op("max_1",     8388607,   1, 16'h7FFF, 8'd0,   1'b1, 1'b0, 24, 0,  1'b0);
    run_op("min_m128", -8388608, -128, 16'h7FFF, 8'd0,  1'b1, 1'b0, 24, 0,  1'b0);
    run_op("qmin_exact", 4194304, -128, 16'h8000, 8'd0, 1'b0, 1'b0, 24, 0,  1'b0);
    run_op("p5_zero",   5,         0, 16'h7FFF, 8'd0,   1'b0, 1'b1, 1,  3,  1'b0);
    run_op("m5_zero",  -5,         0, 16'h8000, 8'd0,   1'b0, 1'b1, 1,  0,  1'b0);
    run_op("p77_m5",    77,       -5, 16'hFFF1, 8'd2,   1'b0, 1'b0, 24, 0,  1'b0);

    // Abort an operation during CALC with an asynchronous reset.
    @(negedge ap_clk);
    bus.in_valid = 1'b1;
    bus.dividend = 24'd1000;
    bus.divisor  = 8'd7;
    @(posedge ap_clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("post_reset_valid", 32'(bus.out_valid), 32'd0);

    run_op("p100_3",    100,       3, 16'd33,   8'd1,   1'b0, 1'b0, 24, 0,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
